// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause control and a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value at terminal count instead of stopping.
module countdown_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             busy_reg;
   logic             busy_next;
   logic             done_reg;
   logic             done_next;
   logic [WIDTH-1:0] terminal_val;

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reload_reg <= '0;
      end else if (load) begin
         reload_reg <= load_val;
      end
   end

   assign terminal_val = reload_reg;
`else
   assign terminal_val = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   // Priority: load > pause > start > tick; done is a pulse, so it defaults low.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      done_next  = 1'b0;
      if (load) begin
         count_next = load_val;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && (count_reg != '0)) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (pause) begin
                  state_next = PAUSED;
               end else if (tick) begin
                  if (count_reg == ONE) begin
                     count_next = terminal_val;
                     done_next  = 1'b1;
`ifndef COUNTDOWN_AUTORELOAD_EN
                     state_next = DONE;
`endif
                  end else if (count_reg > ONE) begin
                     count_next = count_reg - ONE;
                  end
               end
            end
            PAUSED: begin
               if (start && !pause) begin
                  state_next = RUN;
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
      busy_next = (state_next == RUN) || (state_next == PAUSED);
   end

   assign count = count_reg;
   assign busy  = busy_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; autoreload checks run when COUNTDOWN_AUTORELOAD_EN is defined.
module tb_countdown_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       pause;
   logic       tick;
   logic [3:0] count;
   logic       busy;
   logic       done;

   int checks;
   int errors;

   countdown_timer #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .tick     (tick),
      .count    (count),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] c, input logic b, input logic d);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".done"},  32'(done),  32'(d));
      $display("%0t %s count=%0d busy=%0d done=%0d", $time, tag, count, busy, done);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; pause = 1'b0; tick = 1'b0;
      step();
      chk_out("reset", 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // load 5
      load = 1'b1; load_val = 4'd5;
      step();
      load = 1'b0;
      chk_out("load5", 4'd5, 1'b0, 1'b0);

`ifndef COUNTDOWN_AUTORELOAD_EN
      // basic countdown to DONE
      load = 1'b1; load_val = 4'd3;
      step();
      load = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      chk_out("cd_start", 4'd3, 1'b1, 1'b0);
      start = 1'b0;
      step();
      chk_out("cd_2", 4'd2, 1'b1, 1'b0);
      step();
      chk_out("cd_1", 4'd1, 1'b1, 1'b0);
      step();
      chk_out("cd_term", 4'd0, 1'b0, 1'b1);
      step();
      chk_out("cd_after", 4'd0, 1'b0, 1'b0);
      start = 1'b1; pause = 1'b1;
      step();
      chk_out("done_ignore", 4'd0, 1'b0, 1'b0);
      start = 1'b0; pause = 1'b0;
`else
      // autoreload: 4,3,2,1,4,3,2,1,4 with done on each reload edge
      load = 1'b1; load_val = 4'd4;
      step();
      load = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      chk_out("ar_start", 4'd4, 1'b1, 1'b0);
      start = 1'b0;
      step(); chk_out("ar_3a", 4'd3, 1'b1, 1'b0);
      step(); chk_out("ar_2a", 4'd2, 1'b1, 1'b0);
      step(); chk_out("ar_1a", 4'd1, 1'b1, 1'b0);
      step(); chk_out("ar_rl1", 4'd4, 1'b1, 1'b1);
      step(); chk_out("ar_3b", 4'd3, 1'b1, 1'b0);
      step(); chk_out("ar_2b", 4'd2, 1'b1, 1'b0);
      step(); chk_out("ar_1b", 4'd1, 1'b1, 1'b0);
      step(); chk_out("ar_rl2", 4'd4, 1'b1, 1'b1);
`endif

      // pause/resume
      tick = 1'b0;
      load = 1'b1; load_val = 4'd9;
      step();
      chk_out("pr_load", 4'd9, 1'b0, 1'b0);
      load = 1'b0; start = 1'b1;
      step();
      chk_out("pr_start", 4'd9, 1'b1, 1'b0);
      start = 1'b0;
      step();
      chk_out("pr_notick", 4'd9, 1'b1, 1'b0);
      tick = 1'b1;
      step(); chk_out("pr_8", 4'd8, 1'b1, 1'b0);
      step(); chk_out("pr_7", 4'd7, 1'b1, 1'b0);
      step(); chk_out("pr_6", 4'd6, 1'b1, 1'b0);
      pause = 1'b1;
      step();
      chk_out("pr_pause", 4'd6, 1'b1, 1'b0);
      pause = 1'b0;
      step(); chk_out("pr_hold1", 4'd6, 1'b1, 1'b0);
      step(); chk_out("pr_hold2", 4'd6, 1'b1, 1'b0);
      start = 1'b1; pause = 1'b1;
      step();
      chk_out("pr_both", 4'd6, 1'b1, 1'b0);
      pause = 1'b0;
      step();
      chk_out("pr_resume", 4'd6, 1'b1, 1'b0);
      start = 1'b0;
      step();
      chk_out("pr_5", 4'd5, 1'b1, 1'b0);

      // start with zero count is ignored
      tick = 1'b0;
      load = 1'b1; load_val = 4'd0;
      step();
      chk_out("z_load", 4'd0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      chk_out("z_start", 4'd0, 1'b0, 1'b0);
      start = 1'b0;
      step();
      chk_out("z_after", 4'd0, 1'b0, 1'b0);

      // load on the terminal-count edge wins
      load = 1'b1; load_val = 4'd2;
      step();
      load = 1'b0; start = 1'b1;
      step();
      chk_out("lt_start", 4'd2, 1'b1, 1'b0);
      start = 1'b0;
      step();
      chk_out("lt_1", 4'd1, 1'b1, 1'b0);
      load = 1'b1; load_val = 4'd7;
      step();
      chk_out("lt_load", 4'd7, 1'b0, 1'b0);
      load = 1'b0;
      step();
      chk_out("lt_idle", 4'd7, 1'b0, 1'b0);

      // asynchronous reset between edges
      load = 1'b1; load_val = 4'd4;
      step();
      load = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk_out("ar_pre", 4'd2, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_async", 4'd0, 1'b0, 1'b0);
      #1;
      rst = 1'b0;
      start = 1'b1;
      step();
      chk_out("rst_start", 4'd0, 1'b0, 1'b0);
      start = 1'b0;
      step();
      chk_out("rst_idle", 4'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with start/pause control and a terminal-count pulse; the decrementing counterpart to the lab up-counter. It sits between the front-panel control logic (load/start/pause strobes, tick from a clock divider) and the display/alarm logic, which consumes `count`, `busy` and `done`. All outputs are registered, and the counter never underflows.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  in  1: clock. All state changes occur on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `load`  in  1: when high, captures `load_val` into the counter.
- `load_val`  in  WIDTH: start value for the countdown.
- `start`  in  1: starts the countdown from IDLE, or resumes it from PAUSED.
- `pause`  in  1: freezes the countdown while in RUN.
- `tick`  in  1: decrement enable. Single-cycle strobes from the divider, or held high to count every clock.
- `count`  out  WIDTH: current counter value.
- `busy`  out  1: high in the RUN and PAUSED states.
- `done`  out  1: one-cycle terminal-count pulse.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset (asynchronous, effective immediately):
  - state = IDLE
  - `count` = 0
  - `busy` = 0
  - `done` = 0
  - reload register = 0
- Input priority at each edge: `load` > `pause` > `start` > `tick`.
- `load`, in any state:
  - `count` <= `load_val`; the reload register also captures `load_val`.
  - Next state is IDLE and `done` is 0.
  - `tick`, `start` and `pause` are ignored in that cycle.
- IDLE:
  - `start` with `count` != 0 moves to RUN. The first decrement can happen on the next edge that has `tick` = 1.
  - `start` with `count` == 0 is ignored: the state stays IDLE and no `done` pulse is produced.
- RUN:
  - On each edge with `tick` = 1 and `count` > 1, `count` <= `count` - 1.
  - On an edge with `tick` = 1 and `count` == 1, terminal count is reached (see Configuration). `done` <= 1 for exactly one cycle.
  - `pause` moves to PAUSED with `count` held. If `pause` and `tick` arrive on the same edge, `pause` wins and there is no decrement.
- PAUSED:
  - `count` holds.
  - `start` returns to RUN; no decrement occurs on that edge.
  - `pause` is ignored. If `start` and `pause` are both high, the state stays PAUSED.
- DONE:
  - `count` holds at 0; `start`, `pause` and `tick` are ignored.
  - Only `load` or `rst` leaves this state.
- `busy` is registered and reflects the state after the edge.
- Arithmetic is unsigned, modulo-free, and never wraps below 0. A terminal count is taken only from 1, so a count of 0 never decrements.

## Timing
- Latency from `load` to `count` = `load_val`: 1 edge.
- Latency from `start` (IDLE) to `busy` = 1: 1 edge.
- `done` rises on the same edge at which `count` takes its terminal value, and falls on the next edge unconditionally.
- Reload period with the macro enabled and `tick` held high: `done` repeats every N cycles for a loaded value of N.
- A `load` in the same cycle as terminal count wins: `done` = 0 and `count` = `load_val`.
- Asserting `rst` mid-count clears everything asynchronously. After deassertion the block sits in IDLE, and `start` is ignored until a `load` occurs.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`, defined:
  - At terminal count, `count` <= reload register, the state stays RUN, and `done` pulses.
  - `count` is never observed as 0 during RUN.
  - A reload value of 0 is impossible in RUN, because `start` is ignored at 0.
- Macro `COUNTDOWN_AUTORELOAD_EN`, undefined:
  - At terminal count, `count` <= 0, the state moves to DONE, and `busy` <= 0.
  - The reload register is not instantiated.

## Test plan
- Reset and load: `rst` pulse, then `load_val`=5 with `load` -> after reset `count`=0, `busy`=0, `done`=0; after the `load` edge, `count`=5.
- Basic countdown (macro off), `tick` high, load 3, then `start` -> `count` 3, 2, 1, 0 on successive edges. `done` is high only in the cycle where `count`=0, and `busy` goes 1 then 0 at that edge. A later `start` is ignored.
- Pause/resume: load 9, run until `count`=6, assert `pause` and `tick` on the same edge -> `count` stays 6 in PAUSED. Three cycles later `start` -> RUN, and `count`=5 on the edge after the resume edge.
- Boundary at zero: load 0 then `start` -> stays IDLE, `count`=0, no `done`. Also, `load`=7 on the same edge as terminal count -> `count`=7, `done`=0, state IDLE.
- Auto-reload (macro on): load 4, `tick` high, `start` -> `count` sequence 4, 3, 2, 1, 4, 3, ... with `done` every 4th cycle. `count` is never 0 and `busy` stays 1.
- Async reset mid-run: assert `rst` between edges while `count`=2 -> outputs clear immediately. After release, `start` is ignored and `count` stays 0.
